draw_menu_text: RTL

Pixel-side reader for the menu text ROMs. Walks the VGA raster, converts pixel coordinates inside a fixed 128×256-pixel text box into a 16×16 character address (`char_xy`), accepts the 7-bit character code returned one cycle later, looks up the 8×16 glyph in an internal font ROM, and overlays the glyph pixels onto the incoming RGB stream. It sits in the VGA pipeline between the background/menu drawing stage and the output register. Timing signals are delayed to stay aligned with RGB.

---
 rtl/vga_pkg.sv | 49 ++++
 rtl/font_rom.sv | 30 +++
 rtl/draw_menu_text.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : vga_pkg                                                      |
// | Description : Shared constants, types and the glyph generator used by the  |
// |               menu text drawing stage.                                     |
// |               - CHAR_W/CHAR_H     : glyph cell size in pixels              |
// |               - TEXT_COLS/ROWS    : character grid of the text box         |
// |               - TEXT_BOX_W/H      : text box size in pixels                |
// |               - vga_sig_t         : raster position, timing and RGB bundle |
// |               - font_glyph_row()  : 8-pixel glyph line for a code/line     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vga_pkg;

   localparam int CHAR_W     = 8;
   localparam int CHAR_H     = 16;
   localparam int TEXT_COLS  = 16;
   localparam int TEXT_ROWS  = 16;
   localparam int TEXT_BOX_W = CHAR_W * TEXT_COLS;
   localparam int TEXT_BOX_H = CHAR_H * TEXT_ROWS;

   // Everything that rides along the pixel pipeline untouched (except rgb,
   // which the last stage may replace with the text colour).
   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_sig_t;

   // Glyph content: line 0 of every cell is blank so adjacent text rows stay
   // separated; the remaining lines form a code-dependent bit pattern. Bit 7
   // is the leftmost pixel of the cell.
   function automatic logic [7:0] font_glyph_row(input logic [6:0] code,
                                                 input logic [3:0] line);
      logic [7:0] row;
      if (line == 4'd0) begin
         row = 8'h00;
      end else begin
         row = {code, 1'b1} ^ {line, line};
      end
      return row;
   endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/font_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : font_rom                                                     |
// | Description : 2048 x 8 glyph ROM with a registered read port. Address is   |
// |               {char_code[6:0], line[3:0]}; data is one 8-pixel glyph line. |
// | Ports       : clk              - pixel clock                               |
// |               addr[10:0]       - {code, line}                              |
// |               char_line_pixels - registered glyph byte, bit 7 = leftmost   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module font_rom
   import vga_pkg::*;
(
   input  logic        clk,
   input  logic [10:0] addr,
   output logic [7:0]  char_line_pixels
);

   logic [7:0] pixels_q;

   // ROM contents come from the glyph generator, so this maps onto a plain
   // registered lookup table.
   always_ff @(posedge clk) begin
      pixels_q <= font_glyph_row(addr[10:4], addr[3:0]);
   end

   assign char_line_pixels = pixels_q;

endmodule : font_rom
`default_nettype wire

// File: rtl/draw_menu_text.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : draw_menu_text                                               |
// | Description : Overlays a 16x16-character (128x256 pixel) text box onto the |
// |               VGA pixel stream. Issues a character address to the text    |
// |               ROM, looks up the returned code in the font ROM and paints   |
// |               set glyph pixels with TEXT_COLOR. Fixed 4-clock latency on   |
// |               every output.                                                |
// | Ports       : clk, rst                 - pixel clock, sync active-high rst |
// |               hcount_in, vcount_in     - raster position                   |
// |               hsync/vsync/hblnk/vblnk_in - timing                          |
// |               rgb_in                   - background pixel (RGB444)         |
// |               char_code                - text ROM data, 1 clk after char_xy|
// |               char_xy                  - {row, col} text ROM address       |
// |               *_out                    - 4-clock delayed timing/position   |
// |               rgb_out                  - composited pixel                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module draw_menu_text
   import vga_pkg::*;
#(
   parameter logic [10:0] TEXT_X     = 11'd256,
   parameter logic [10:0] TEXT_Y     = 11'd128,
   parameter logic [11:0] TEXT_COLOR = 12'hFFF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [6:0]  char_code,
   output logic [7:0]  char_xy,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   // ------------------------------------------------------------------
   // Stage 0: box test and cell decomposition on the raw inputs
   // ------------------------------------------------------------------
   logic       in_x, in_y, in_box;
   logic [6:0] rel_x;   // 0..127 inside the box
   logic [7:0] rel_y;   // 0..255 inside the box
   logic [7:0] char_xy_d;
   vga_sig_t   in_sig;

   // Compare in 12 bits so a box placed near the top of the 11-bit range
   // cannot wrap its far edge.
   assign in_x   = (hcount_in >= TEXT_X) &&
                   ({1'b0, hcount_in} < ({1'b0, TEXT_X} + 12'(TEXT_BOX_W)));
   assign in_y   = (vcount_in >= TEXT_Y) &&
                   ({1'b0, vcount_in} < ({1'b0, TEXT_Y} + 12'(TEXT_BOX_H)));
   assign in_box = in_x && in_y;

   assign rel_x = 7'(hcount_in - TEXT_X);
   assign rel_y = 8'(vcount_in - TEXT_Y);

   assign char_xy_d = in_box ? {rel_y[7:4], rel_x[6:3]} : 8'h00;

   always_comb begin
      in_sig.hcount = hcount_in;
      in_sig.vcount = vcount_in;
      in_sig.hsync  = hsync_in;
      in_sig.vsync  = vsync_in;
      in_sig.hblnk  = hblnk_in;
      in_sig.vblnk  = vblnk_in;
      in_sig.rgb    = rgb_in;
   end

   // ------------------------------------------------------------------
   // Delay line. draw*_q already folds in the blanking flags, so the
   // output stage only needs the glyph bit.
   // ------------------------------------------------------------------
   logic [7:0] char_xy_q;
   vga_sig_t   sig1_q, sig2_q, sig3_q, out_q;
   logic       draw1_q, draw2_q, draw3_q;
   logic [3:0] line1_q, line2_q;
   logic [2:0] bit1_q, bit2_q, bit3_q;

   logic [7:0] glyph_byte;
   logic       pixel_on;
   vga_sig_t   out_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         char_xy_q <= 8'h00;
         sig1_q    <= '0;
         sig2_q    <= '0;
         sig3_q    <= '0;
         out_q     <= '0;
         draw1_q   <= 1'b0;
         draw2_q   <= 1'b0;
         draw3_q   <= 1'b0;
         line1_q   <= 4'd0;
         line2_q   <= 4'd0;
         bit1_q    <= 3'd0;
         bit2_q    <= 3'd0;
         bit3_q    <= 3'd0;
      end else begin
         // Stage 1: address goes out to the text ROM
         char_xy_q <= char_xy_d;
         sig1_q    <= in_sig;
         draw1_q   <= in_box && !hblnk_in && !vblnk_in;
         line1_q   <= rel_y[3:0];
         bit1_q    <= rel_x[2:0];
         // Stage 2: char_code valid, font address formed from it
         sig2_q    <= sig1_q;
         draw2_q   <= draw1_q;
         line2_q   <= line1_q;
         bit2_q    <= bit1_q;
         // Stage 3: font ROM has registered the glyph byte
         sig3_q    <= sig2_q;
         draw3_q   <= draw2_q;
         bit3_q    <= bit2_q;
         // Stage 4: output register
         out_q     <= out_d;
      end
   end

   font_rom u_font_rom (
      .clk              (clk),
      .addr             ({char_code, line2_q}),
      .char_line_pixels (glyph_byte)
   );

   assign pixel_on = glyph_byte[3'd7 - bit3_q];

   always_comb begin
      out_d = sig3_q;
      if (draw3_q && pixel_on) begin
         out_d.rgb = TEXT_COLOR;
      end
   end

   assign char_xy    = char_xy_q;
   assign hcount_out = out_q.hcount;
   assign vcount_out = out_q.vcount;
   assign hsync_out  = out_q.hsync;
   assign vsync_out  = out_q.vsync;
   assign hblnk_out  = out_q.hblnk;
   assign vblnk_out  = out_q.vblnk;
   assign rgb_out    = out_q.rgb;

endmodule : draw_menu_text
`default_nettype wire
